demux2_stream: RTL and testbench



---
 rtl/demux2_stream_pkg.sv | 11 +
 rtl/demux2_stream_sync_fifo.sv | 44 ++++
 rtl/demux2_stream.sv | 40 ++++
 tb/tb_demux2_stream.sv | 108 ++++++++++
 4 files changed

// File: rtl/demux2_stream_pkg.sv
// demux2_stream_pkg: channel select encodings and width helper shared by the demux
package demux2_stream_pkg;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/demux2_stream_sync_fifo.sv
// sync_fifo: registered-output synchronous FIFO with occupancy count, no fall-through
module sync_fifo
  import demux2_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = clog2(DEPTH),
  localparam int CNT_W = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign empty = count == '0;
  assign full = count == CNT_W'(DEPTH);
  assign wr = wr_en & ~full;
  assign rd = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];
  // storage, wrapping pointers and occupancy; reset clears contents so the head reads 0
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNT_W'(wr) - CNT_W'(rd);
    end
  end
endmodule

// File: rtl/demux2_stream.sv
// demux2_stream: steers each accepted beat into one of two per-channel FIFOs by sel
module demux2_stream
  import demux2_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sel,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout_0,
  output logic             dout_0_valid,
  input  logic             dout_0_ready,
  output logic [WIDTH-1:0] dout_1,
  output logic             dout_1_valid,
  input  logic             dout_1_ready,
  output logic [CNT_W-1:0] count_0,
  output logic [CNT_W-1:0] count_1
);
  logic full_0, full_1, empty_0, empty_1, wr_en_0, wr_en_1;
  assign din_ready = ~rst & ~(sel == CH1 ? full_1 : full_0);
  assign wr_en_0 = din_valid & din_ready & (sel == CH0);
  assign wr_en_1 = din_valid & din_ready & (sel == CH1);
  assign dout_0_valid = ~empty_0;
  assign dout_1_valid = ~empty_1;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_0 (
    .clk(clk), .rst(rst), .wr_en(wr_en_0), .wr_data(din), .rd_en(dout_0_ready),
    .rd_data(dout_0), .empty(empty_0), .full(full_0), .count(count_0)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_1 (
    .clk(clk), .rst(rst), .wr_en(wr_en_1), .wr_data(din), .rd_en(dout_1_ready),
    .rd_data(dout_1), .empty(empty_1), .full(full_1), .count(count_1)
  );
endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream: directed and random stimulus checked against a queue-based model
module tb_demux2_stream;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  logic clk = 0, rst, din_valid, sel, din_ready, dout_0_ready, dout_1_ready;
  logic dout_0_valid, dout_1_valid;
  logic [WIDTH-1:0] din, dout_0, dout_1;
  logic [1:0] count_0, count_1;
  int total = 0, bad = 0;
  logic [WIDTH-1:0] q0[$], q1[$];

  demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sel(sel), .din_ready(din_ready),
    .dout_0(dout_0), .dout_0_valid(dout_0_valid), .dout_0_ready(dout_0_ready),
    .dout_1(dout_1), .dout_1_valid(dout_1_valid), .dout_1_ready(dout_1_ready),
    .count_0(count_0), .count_1(count_1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, check outputs against the model, then advance the model
  task automatic cyc(input logic r, input logic v, input logic s, input logic [7:0] d,
                     input logic r0, input logic r1);
    bit acc, p0, p1;
    rst = r; din_valid = v; sel = s; din = d; dout_0_ready = r0; dout_1_ready = r1;
    #1;
    chk("din_ready", 32'(din_ready), 32'(!r && (s ? q1.size() : q0.size()) < DEPTH));
    chk("valid_0", 32'(dout_0_valid), 32'(q0.size() > 0));
    chk("valid_1", 32'(dout_1_valid), 32'(q1.size() > 0));
    chk("count_0", 32'(count_0), 32'(q0.size()));
    chk("count_1", 32'(count_1), 32'(q1.size()));
    if (q0.size() > 0) chk("dout_0", 32'(dout_0), 32'(q0[0]));
    if (q1.size() > 0) chk("dout_1", 32'(dout_1), 32'(q1[0]));
    acc = !r && v && (s ? q1.size() : q0.size()) < DEPTH;
    p0 = !r && r0 && q0.size() > 0;
    p1 = !r && r1 && q1.size() > 0;
    @(posedge clk);
    if (r) begin
      q0.delete(); q1.delete();
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (s) q1.push_back(d); else q0.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    rst = 1; din_valid = 0; sel = 0; din = 0; dout_0_ready = 0; dout_1_ready = 0;
    @(posedge clk); #1;
    chk("rst_dout_0", 32'(dout_0), 32'h0);
    chk("rst_dout_1", 32'(dout_1), 32'h0);
    cyc(1, 0, 0, 0, 0, 0);
    // alternating beats with both consumers ready
    cyc(0, 1, 0, 8'h11, 1, 1);
    cyc(0, 1, 1, 8'h22, 1, 1);
    cyc(0, 1, 0, 8'h33, 1, 1);
    cyc(0, 1, 1, 8'h44, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    // fill channel 0, third beat refused, then redirect to channel 1
    cyc(0, 1, 0, 8'h51, 0, 1);
    cyc(0, 1, 0, 8'h52, 0, 1);
    cyc(0, 1, 0, 8'h53, 0, 1);
    chk("full_count_0", 32'(count_0), 32'd2);
    cyc(0, 1, 1, 8'h54, 0, 1);
    // full FIFO 0 popped while a beat is offered: refused this cycle, accepted next
    cyc(0, 1, 0, 8'h55, 1, 1);
    chk("freed_count_0", 32'(count_0), 32'd1);
    cyc(0, 1, 0, 8'h55, 0, 1);
    chk("refill_count_0", 32'(count_0), 32'd2);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    // steady push and pop on channel 1 across pointer wraps
    cyc(0, 1, 1, 8'd0, 1, 0);
    for (int i = 1; i < 10; i++) cyc(0, 1, 1, 8'(i), 1, 1);
    cyc(0, 0, 1, 0, 1, 1);
    cyc(0, 0, 1, 0, 1, 1);
    // fill both, reset mid-operation, then a lone beat on channel 1
    cyc(0, 1, 0, 8'hA0, 0, 0);
    cyc(0, 1, 0, 8'hA1, 0, 0);
    cyc(0, 1, 1, 8'hB0, 0, 0);
    cyc(0, 1, 1, 8'hB1, 0, 0);
    cyc(1, 1, 1, 8'hEE, 1, 1);
    chk("post_rst_count_0", 32'(count_0), 32'd0);
    chk("post_rst_count_1", 32'(count_1), 32'd0);
    cyc(0, 1, 1, 8'hC0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    // random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom), 8'($urandom),
          1'($urandom), 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
